// File: rtl/cam_config.sv
// Walks the OV7670 register ROM and issues one SCCB write per {reg,value} entry.
// Handles the 0xFFF0 pause marker and stops at the 0xFFFF end marker.
module cam_config #(
    parameter int CLK_F    = 25_000_000,
    parameter int DELAY_MS = 10
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    output logic [7:0]  o_rom_addr,
    input  logic [15:0] i_rom_data,
    output logic        o_sccb_start,
    output logic [7:0]  o_sccb_addr,
    output logic [7:0]  o_sccb_data,
    input  logic        i_sccb_ready,
    output logic        o_done
);

    localparam int DELAY_CYCLES = CLK_F / 1000 * DELAY_MS;
    localparam int CNT_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DELAY_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        SEND,
        WAIT_LO,
        WAIT_HI,
        DELAY,
        NEXT,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] delay_cnt;

    // The start pulse defaults low every cycle, so it can only last one cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            o_rom_addr   <= 8'h00;
            o_sccb_start <= 1'b0;
            o_sccb_addr  <= 8'h00;
            o_sccb_data  <= 8'h00;
            o_done       <= 1'b0;
            delay_cnt    <= '0;
        end else begin
            o_sccb_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        o_rom_addr <= 8'h00;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    state <= DECODE;
                end
                DECODE: begin
                    if (i_rom_data == 16'hFFFF) begin
                        o_done <= 1'b1;
                        state  <= DONE;
                    end else if (i_rom_data == 16'hFFF0) begin
                        delay_cnt <= '0;
                        state     <= DELAY;
                    end else begin
                        o_sccb_addr <= i_rom_data[15:8];
                        o_sccb_data <= i_rom_data[7:0];
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (i_sccb_ready) begin
                        o_sccb_start <= 1'b1;
                        state        <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (!i_sccb_ready) begin
                        state <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (i_sccb_ready) begin
                        state <= NEXT;
                    end
                end
                DELAY: begin
                    if (delay_cnt == CNT_MAX) begin
                        state <= NEXT;
                    end else begin
                        delay_cnt <= delay_cnt + 1'b1;
                    end
                end
                // Address 255 is the last ROM slot; finish rather than wrap.
                NEXT: begin
                    if (o_rom_addr == 8'hFF) begin
                        o_done <= 1'b1;
                        state  <= DONE;
                    end else begin
                        o_rom_addr <= o_rom_addr + 8'h01;
                        state      <= FETCH;
                    end
                end
                DONE: begin
                    if (i_start) begin
                        o_done     <= 1'b0;
                        o_rom_addr <= 8'h00;
                        state      <= FETCH;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_config.sv
// Directed bench for cam_config with a registered ROM model and a 20-cycle busy SCCB master model.
module tb_cam_config;

    localparam int BUSY = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        sccb_start;
    logic [7:0]  sccb_addr;
    logic [7:0]  sccb_data;
    logic        sccb_ready;
    logic        done;

    logic [15:0] rom [0:255];
    int          busy_cnt = 0;
    logic        hold_low = 1'b0;
    logic [15:0] wlog [0:63];
    int          wcnt = 0;
    logic        prev_start = 1'b0;
    int          dbl_cnt = 0;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    cam_config #(.CLK_F(1000), .DELAY_MS(5)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .o_rom_addr   (rom_addr),
        .i_rom_data   (rom_data),
        .o_sccb_start (sccb_start),
        .o_sccb_addr  (sccb_addr),
        .o_sccb_data  (sccb_data),
        .i_sccb_ready (sccb_ready),
        .o_done       (done)
    );

    // ROM answers one cycle after the address is presented.
    always @(posedge clk) rom_data <= rom[rom_addr];

    // SCCB master: goes busy for BUSY cycles after accepting a start.
    always @(posedge clk) begin
        if (sccb_start) busy_cnt <= BUSY;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign sccb_ready = (busy_cnt == 0) && !hold_low;

    // Log every write and count back-to-back start pulses.
    always @(posedge clk) begin
        prev_start <= sccb_start;
        if (prev_start && sccb_start) dbl_cnt <= dbl_cnt + 1;
        if (sccb_start && wcnt < 64) begin
            wlog[wcnt] <= {sccb_addr, sccb_data};
            wcnt       <= wcnt + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Pulse i_start for one cycle; returns at the negedge after the sampling edge.
    task automatic applyStimulus();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic loadRom(input logic [15:0] w0, input logic [15:0] w1,
                           input logic [15:0] w2, input logic [15:0] w3,
                           input logic [15:0] w4);
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = w3; rom[4] = w4;
    endtask

    task automatic waitDone(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic waitWrites(input string tag, input int target, input int budget);
        int n = 0;
        while (wcnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 32'(wcnt >= target), 32'd1);
    endtask

    function automatic logic [15:0] logAt(input int idx);
        return (idx >= 0 && idx < wcnt && idx < 64) ? wlog[idx] : 16'hDEAD;
    endfunction

    initial begin
        int base;
        int k;
        start = 1'b0;
        rst   = 1'b1;
        loadRom(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        repeat (3) @(negedge clk);
        checkOutput("reset_rom_addr",  {24'd0, rom_addr},  32'd0);
        checkOutput("reset_start",     {31'd0, sccb_start}, 32'd0);
        checkOutput("reset_sccb_addr", {24'd0, sccb_addr}, 32'd0);
        checkOutput("reset_sccb_data", {24'd0, sccb_data}, 32'd0);
        checkOutput("reset_done",      {31'd0, done},      32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("idle_no_start", {31'd0, sccb_start}, 32'd0);

        // Two writes then end marker, with exact start latency.
        $display("[TB] two-entry ROM");
        loadRom(16'h1280, 16'h1204, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        base = wcnt;
        applyStimulus();
        repeat (2) @(negedge clk);
        checkOutput("lat_not_yet",  {31'd0, sccb_start}, 32'd0);
        checkOutput("lat_addr",     {24'd0, sccb_addr},  32'h12);
        checkOutput("lat_data",     {24'd0, sccb_data},  32'h80);
        @(negedge clk);
        checkOutput("lat_start",    {31'd0, sccb_start}, 32'd1);
        @(negedge clk);
        checkOutput("lat_one_cycle", {31'd0, sccb_start}, 32'd0);
        waitDone("t1_done", 300);
        checkOutput("t1_count",    32'(wcnt - base), 32'd2);
        checkOutput("t1_w0",       {16'd0, logAt(base)},     32'h1280);
        checkOutput("t1_w1",       {16'd0, logAt(base + 1)}, 32'h1204);
        checkOutput("t1_rom_addr", {24'd0, rom_addr}, 32'd2);
        checkOutput("t1_ready",    {31'd0, sccb_ready}, 32'd1);

        // Delay marker: 5-cycle pause before entry 1 is fetched.
        $display("[TB] delay entry");
        loadRom(16'hFFF0, 16'h1100, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        base = wcnt;
        applyStimulus();
        k = 1;
        while (!sccb_start && k < 60) begin
            @(negedge clk);
            k++;
        end
        checkOutput("t2_start_cycle", 32'(k), 32'd12);
        checkOutput("t2_addr", {24'd0, sccb_addr}, 32'h11);
        checkOutput("t2_data", {24'd0, sccb_data}, 32'h00);
        waitDone("t2_done", 300);
        checkOutput("t2_count", 32'(wcnt - base), 32'd1);

        // End marker at address 0, then restart from DONE.
        $display("[TB] empty ROM");
        loadRom(16'hFFFF, 16'h1111, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        base = wcnt;
        applyStimulus();
        checkOutput("t3_done_drop", {31'd0, done}, 32'd0);
        checkOutput("t3_addr0",     {24'd0, rom_addr}, 32'd0);
        waitDone("t3_done", 50);
        applyStimulus();
        checkOutput("t3_done_drop2", {31'd0, done}, 32'd0);
        waitDone("t3_done2", 50);
        checkOutput("t3_count", 32'(wcnt - base), 32'd0);
        checkOutput("t3_rom_addr", {24'd0, rom_addr}, 32'd0);

        // Repeated i_start during entry 1 must be ignored.
        $display("[TB] start spam");
        loadRom(16'h0A01, 16'h0B02, 16'h0C03, 16'h0D04, 16'hFFFF);
        base = wcnt;
        applyStimulus();
        waitWrites("t4_reach_e1", base + 2, 200);
        repeat (4) applyStimulus();
        waitDone("t4_done", 400);
        checkOutput("t4_count", 32'(wcnt - base), 32'd4);
        checkOutput("t4_w0", {16'd0, logAt(base)},     32'h0A01);
        checkOutput("t4_w1", {16'd0, logAt(base + 1)}, 32'h0B02);
        checkOutput("t4_w2", {16'd0, logAt(base + 2)}, 32'h0C03);
        checkOutput("t4_w3", {16'd0, logAt(base + 3)}, 32'h0D04);

        // Reset while waiting for entry 2 to complete.
        $display("[TB] reset mid transfer");
        loadRom(16'h2001, 16'h2102, 16'h2203, 16'hFFFF, 16'hFFFF);
        base = wcnt;
        applyStimulus();
        waitWrites("t5_reach_e2", base + 3, 300);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t5_rst_rom_addr", {24'd0, rom_addr},  32'd0);
        checkOutput("t5_rst_start",    {31'd0, sccb_start}, 32'd0);
        checkOutput("t5_rst_sccb_addr", {24'd0, sccb_addr}, 32'd0);
        checkOutput("t5_rst_sccb_data", {24'd0, sccb_data}, 32'd0);
        checkOutput("t5_rst_done",     {31'd0, done},      32'd0);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("t5_idle_count", 32'(wcnt - base), 32'd3);
        checkOutput("t5_idle_done",  {31'd0, done}, 32'd0);
        base = wcnt;
        applyStimulus();
        waitDone("t5_done", 300);
        checkOutput("t5_count", 32'(wcnt - base), 32'd3);
        checkOutput("t5_w0", {16'd0, logAt(base)}, 32'h2001);

        // Ready held low stalls SEND with no pulse.
        $display("[TB] ready stall");
        loadRom(16'h3355, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        base = wcnt;
        hold_low = 1'b1;
        applyStimulus();
        repeat (100) @(negedge clk);
        checkOutput("t6_stalled", 32'(wcnt - base), 32'd0);
        hold_low = 1'b0;
        waitWrites("t6_released", base + 1, 20);
        repeat (2) @(negedge clk);
        checkOutput("t6_count", 32'(wcnt - base), 32'd1);
        checkOutput("t6_w0", {16'd0, logAt(base)}, 32'h3355);
        waitDone("t6_done", 100);

        checkOutput("no_double_start", 32'(dbl_cnt), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
